// File: rtl/eq_codec_pkg.sv
// Shared definitions for the equalizer-to-codec serial interface.
// Holds sample width, frame counter width, the counter values at which the
// transmit side acts, and the counter bit positions that form the codec clocks.
package eq_codec_pkg;

  localparam int SMPL_W = 16;
  localparam int CNT_W  = 11;

  // Counter values at which per-frame events happen.
  localparam logic [CNT_W-1:0] FRAME_LATCH_CNT = 11'h7FF;
  localparam logic [CNT_W-1:0] REQ_CNT         = 11'h400;

  // Counter bits that directly form the codec clocks.
  localparam int MCLK_BIT  = 1;
  localparam int SCLK_BIT  = 4;
  localparam int LRCLK_BIT = 10;

  typedef logic signed [SMPL_W-1:0] smpl_t;

  // Serial bit for position k of a 32-bit slot.
  // Slot 0 is the one-bit delay after the LRCLK edge, slots 1..16 carry the
  // sample MSB first, and the rest are zero pad.
  function automatic logic slot_bit(input smpl_t s, input logic [4:0] k);
    logic [3:0] idx;
    logic       b;
    b   = 1'b0;
    idx = 4'(5'd16 - k);
    if (k >= 5'd1 && k <= 5'd16) b = s[idx];
    return b;
  endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Free-running frame counter and the codec clocks derived from it.
// Shared by the transmit and receive halves of the codec interface.
//   clk           in  system clock
//   rst_i         in  asynchronous active-high reset
//   cnt_o         out current frame counter value
//   mclk_o        out codec master clock (clk/4)
//   sclk_o        out serial bit clock (clk/32)
//   lrclk_o       out frame clock (clk/2048), 0 = left slot
//   sclk_fall_o   out high in the cycle whose closing edge makes SCLK fall
//   frame_start_o out high in the last cycle of a frame
module codec_clk_gen
  import eq_codec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             mclk_o,
  output logic             sclk_o,
  output logic             lrclk_o,
  output logic             sclk_fall_o,
  output logic             frame_start_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wraps naturally from all-ones back to zero.
  always_comb cnt_d = cnt_q + CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources regardless of block ordering.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Clocks are straight register bits, hence glitch-free.
  assign cnt_o         = cnt_q;
  assign mclk_o        = cnt_q[MCLK_BIT];
  assign sclk_o        = cnt_q[SCLK_BIT];
  assign lrclk_o       = cnt_q[LRCLK_BIT];
  assign sclk_fall_o   = (cnt_q[SCLK_BIT:0] == '1);
  assign frame_start_o = (cnt_q == FRAME_LATCH_CNT);

endmodule

// File: rtl/i2s_tx.sv
// Transmit half of the equalizer-to-codec interface.
// Requests one stereo sample pair per frame, latches it at the frame
// boundary and shifts it out I2S-style on SDin, MSB first.
//   clk      in  50 MHz system clock
//   RST      in  asynchronous active-high reset
//   lft_in   in  signed left sample for a coming frame
//   rht_in   in  signed right sample for a coming frame
//   vld      in  one-cycle strobe qualifying lft_in/rht_in
//   smpl_req out one-cycle pulse asking for the next sample pair
//   underrun out one-cycle pulse: a frame started without fresh data
//   MCLK     out codec master clock
//   SCLK     out serial bit clock
//   LRCLK    out frame clock, 0 = left slot
//   SDin     out serial data to the codec DAC
module i2s_tx
  import eq_codec_pkg::*;
(
  input  logic              clk,
  input  logic              RST,
  input  logic [SMPL_W-1:0] lft_in,
  input  logic [SMPL_W-1:0] rht_in,
  input  logic              vld,
  output logic              smpl_req,
  output logic              underrun,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin
);

  logic [CNT_W-1:0] cnt;
  logic             sclk_fall;
  logic             frame_start;

  codec_clk_gen u_clk_gen (
    .clk           (clk),
    .rst_i         (RST),
    .cnt_o         (cnt),
    .mclk_o        (MCLK),
    .sclk_o        (SCLK),
    .lrclk_o       (LRCLK),
    .sclk_fall_o   (sclk_fall),
    .frame_start_o (frame_start)
  );

  smpl_t hold_lft_q,  hold_lft_d;
  smpl_t hold_rht_q,  hold_rht_d;
  smpl_t frame_lft_q, frame_lft_d;
  smpl_t frame_rht_q, frame_rht_d;
  logic  pend_q,      pend_d;
  logic  sdin_q,      sdin_d;
  logic  req_q,       req_d;
  logic  underrun_q,  underrun_d;

  // Slot index (LRCLK bit plus bit position) that starts at the coming SCLK fall.
  logic [5:0] slot_nxt;

  // NOTE: every signal gets a default before any branch so this block can
  // never infer a latch.
  always_comb begin
    hold_lft_d  = hold_lft_q;
    hold_rht_d  = hold_rht_q;
    frame_lft_d = frame_lft_q;
    frame_rht_d = frame_rht_q;
    pend_d      = pend_q;
    sdin_d      = sdin_q;
    underrun_d  = 1'b0;
    slot_nxt    = cnt[CNT_W-1:SCLK_BIT+1] + 6'd1;

    // Registered so the request is high exactly while cnt == REQ_CNT.
    req_d = (cnt == REQ_CNT - CNT_W'(1));

    // Any strobe overwrites the holding pair: the last one before a frame wins.
    if (vld) begin
      hold_lft_d = lft_in;
      hold_rht_d = rht_in;
      pend_d     = 1'b1;
    end

    // Both channels latch together; a coincident strobe bypasses the holding pair.
    if (frame_start) begin
      if (vld) begin
        frame_lft_d = lft_in;
        frame_rht_d = rht_in;
      end else if (pend_q) begin
        frame_lft_d = hold_lft_q;
        frame_rht_d = hold_rht_q;
      end else begin
        underrun_d = 1'b1;
      end
      pend_d = 1'b0;
    end

    // Bit 0 of each slot is always zero, so using the pre-latch frame
    // registers at the frame boundary is safe.
    if (sclk_fall) begin
      sdin_d = slot_bit(slot_nxt[5] ? frame_rht_q : frame_lft_q, slot_nxt[4:0]);
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      hold_lft_q  <= '0;
      hold_rht_q  <= '0;
      frame_lft_q <= '0;
      frame_rht_q <= '0;
      pend_q      <= 1'b0;
      sdin_q      <= 1'b0;
      req_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_lft_q  <= hold_lft_d;
      hold_rht_q  <= hold_rht_d;
      frame_lft_q <= frame_lft_d;
      frame_rht_q <= frame_rht_d;
      pend_q      <= pend_d;
      sdin_q      <= sdin_d;
      req_q       <= req_d;
      underrun_q  <= underrun_d;
    end
  end

  assign SDin     = sdin_q;
  assign smpl_req = req_q;
  assign underrun = underrun_q;

endmodule
